// File: rtl/endp_packet_injector_ejector.sv
// rtl/endp_packet_injector_ejector.sv - NoC endpoint packet injector/ejector with per-VC credit flow control
//
// Purpose: packet source/sink for one router local port. The injector turns a
//   packet request into head/body/tail flits, gated by per-VC credit counters.
//   The ejector consumes flits, returns one credit per flit and reports each
//   finished packet (source, length, error flag).
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_current_e_addr         this endpoint's address {l,y,x}
//   i_pck_req/dst/len/vc     packet request (level, held until o_pck_ack)
//   o_pck_ack                1-cycle pulse when the request is latched
//   o_busy                   injector not idle
//   o_flit_out, o_flit_out_wr  flit {head,tail,vc_onehot,payload} to router
//   i_credit_in              credits returned by router, one per set bit
//   i_flit_in, i_flit_in_wr  flit from router local output
//   o_credit_out             one credit per consumed flit, one cycle later
//   o_rx_done/src/len/err    finished-packet report, valid with o_rx_done
module endp_packet_injector_ejector #(
  parameter int NX      = 4,
  parameter int NY      = 4,
  parameter int NL      = 1,
  parameter int V       = 2,
  parameter int B       = 4,
  parameter int Fpay    = 32,
  parameter int MAX_PCK = 16,
  localparam int NXw  = (NX > 1) ? $clog2(NX) : 1,
  localparam int NYw  = (NY > 1) ? $clog2(NY) : 1,
  localparam int NLw  = (NL > 1) ? $clog2(NL) : 1,
  localparam int EAw  = NLw + NYw + NXw,
  localparam int Vw   = (V > 1) ? $clog2(V) : 1,
  localparam int LENw = $clog2(MAX_PCK + 1),
  localparam int Fw   = 2 + V + Fpay
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [EAw-1:0]  i_current_e_addr,
  input  logic            i_pck_req,
  input  logic [EAw-1:0]  i_pck_dst,
  input  logic [LENw-1:0] i_pck_len,
  input  logic [Vw-1:0]   i_pck_vc,
  output logic            o_pck_ack,
  output logic            o_busy,
  output logic [Fw-1:0]   o_flit_out,
  output logic            o_flit_out_wr,
  input  logic [V-1:0]    i_credit_in,
  input  logic [Fw-1:0]   i_flit_in,
  input  logic            i_flit_in_wr,
  output logic [V-1:0]    o_credit_out,
  output logic            o_rx_done,
  output logic [EAw-1:0]  o_rx_src,
  output logic [LENw-1:0] o_rx_len,
  output logic            o_rx_err
);

  localparam int CNTw = $clog2(B + 1);
  localparam logic [CNTw-1:0] CRED_INIT = CNTw'(B);
  localparam logic [LENw-1:0] MAX_LEN   = LENw'(MAX_PCK);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  // ---------------------------------------------------------------- injector
  logic [1:0]      r_state;
  logic [EAw-1:0]  r_dst;
  logic [LENw-1:0] r_len;
  logic [LENw-1:0] r_idx;
  logic [Vw-1:0]   r_vc;
  logic [CNTw-1:0] r_cred [V];
  logic            r_pck_ack;
  logic            r_flit_wr;
  logic [Fw-1:0]   r_flit;

  logic [LENw-1:0] w_req_len;
  logic            w_in_flight;
  logic            w_credit_ok;
  logic            w_issue;
  logic            w_last;
  logic [V-1:0]    w_tx_vc_oh;
  logic [V-1:0]    w_dec;
  logic [Fpay-1:0] w_tx_pay;
  logic [Fw-1:0]   w_tx_flit;

  // Length 0 still carries a head, so it becomes a single head+tail flit.
  always_comb begin
    w_req_len = i_pck_len;
    if (i_pck_len == '0) begin
      w_req_len = LENw'(1);
    end else if (i_pck_len > MAX_LEN) begin
      w_req_len = MAX_LEN;
    end
  end

  assign w_in_flight = (r_state == ST_HEAD) || (r_state == ST_BODY);
  // Issue decision uses the counter value before this cycle's credit return.
  assign w_credit_ok = (r_cred[r_vc] != '0);
  assign w_issue     = w_in_flight && w_credit_ok;
  assign w_last      = (r_state == ST_HEAD) ? (r_len == LENw'(1))
                                            : (r_idx == r_len - LENw'(1));
  assign w_tx_vc_oh  = V'(1) << r_vc;
  assign w_tx_pay    = (r_state == ST_HEAD) ? Fpay'({r_len, i_current_e_addr, r_dst})
                                            : Fpay'(r_idx);
  assign w_tx_flit   = {r_state == ST_HEAD, w_last, w_tx_vc_oh, w_tx_pay};
  assign w_dec       = w_issue ? w_tx_vc_oh : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_dst     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_vc      <= '0;
      r_pck_ack <= 1'b0;
      r_flit_wr <= 1'b0;
      r_flit    <= '0;
    end else begin
      r_pck_ack <= 1'b0;
      r_flit_wr <= w_issue;
      // On a stall the last flit stays on the bus.
      if (w_issue) begin
        r_flit <= w_tx_flit;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_pck_req) begin
            r_dst     <= i_pck_dst;
            r_len     <= w_req_len;
            r_vc      <= i_pck_vc;
            r_pck_ack <= 1'b1;
            r_state   <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (w_issue) begin
            r_idx   <= LENw'(1);
            r_state <= w_last ? ST_IDLE : ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_issue) begin
            r_idx <= r_idx + LENw'(1);
            if (w_last) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A credit returned in the same cycle as an issue on that VC cancels out.
  always_ff @(posedge i_clk) begin
    for (int v = 0; v < V; v++) begin
      if (i_reset) begin
        r_cred[v] <= CRED_INIT;
      end else if (w_dec[v] && !i_credit_in[v]) begin
        r_cred[v] <= r_cred[v] - CNTw'(1);
      end else if (!w_dec[v] && i_credit_in[v]) begin
        r_cred[v] <= r_cred[v] + CNTw'(1);
      end
    end
  end

  for (genvar gv = 0; gv < V; gv++) begin : g_cred_chk
    a_cred_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
      !(i_credit_in[gv] && !w_dec[gv] && r_cred[gv] == CRED_INIT));
    a_cred_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
      !(w_dec[gv] && r_cred[gv] == '0));
  end

  // ----------------------------------------------------------------- ejector
  logic [V-1:0]    r_rx_act;
  logic [EAw-1:0]  r_rx_src [V];
  logic [LENw-1:0] r_rx_cnt [V];
  logic [V-1:0]    r_rx_err;
  logic            r_bad_vc;   // an invalid-VC flit was dropped; taints next report
  logic [V-1:0]    r_credit_out;
  logic            r_rx_done;
  logic [EAw-1:0]  r_rx_src_o;
  logic [LENw-1:0] r_rx_len_o;
  logic            r_rx_err_o;

  logic            w_in_head;
  logic            w_in_tail;
  logic [V-1:0]    w_in_vc;
  logic [Fpay-1:0] w_in_pay;
  logic            w_vc_valid;
  logic [V-1:0]    w_vc_low;
  logic [Vw-1:0]   w_rx_idx;
  logic            w_act;
  logic [EAw-1:0]  w_n_src;
  logic [LENw-1:0] w_n_cnt;
  logic            w_n_err;

  assign w_in_head  = i_flit_in[Fw-1];
  assign w_in_tail  = i_flit_in[Fw-2];
  assign w_in_vc    = i_flit_in[Fpay +: V];
  assign w_in_pay   = i_flit_in[Fpay-1:0];
  assign w_vc_valid = $onehot(w_in_vc);
  assign w_vc_low   = w_in_vc & (~w_in_vc + V'(1));

  always_comb begin
    w_rx_idx = '0;
    for (int v = 0; v < V; v++) begin
      if (w_in_vc[v]) begin
        w_rx_idx = Vw'(v);
      end
    end
  end

  assign w_act = r_rx_act[w_rx_idx];

  // A head on an already-active VC abandons the old packet and marks the new one bad.
  // A body/tail on an idle VC starts a bad packet counting from this flit.
  always_comb begin
    if (w_in_head) begin
      w_n_src = w_in_pay[2*EAw-1:EAw];
      w_n_cnt = LENw'(1);
      w_n_err = w_act || (w_in_pay[EAw-1:0] != i_current_e_addr);
    end else begin
      w_n_src = r_rx_src[w_rx_idx];
      w_n_err = r_rx_err[w_rx_idx] || !w_act;
      if (!w_act) begin
        w_n_cnt = LENw'(1);
      end else if (r_rx_cnt[w_rx_idx] == '1) begin
        w_n_cnt = r_rx_cnt[w_rx_idx];
      end else begin
        w_n_cnt = r_rx_cnt[w_rx_idx] + LENw'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_act     <= '0;
      r_rx_err     <= '0;
      r_bad_vc     <= 1'b0;
      r_credit_out <= '0;
      r_rx_done    <= 1'b0;
      r_rx_src_o   <= '0;
      r_rx_len_o   <= '0;
      r_rx_err_o   <= 1'b0;
      for (int v = 0; v < V; v++) begin
        r_rx_src[v] <= '0;
        r_rx_cnt[v] <= '0;
      end
    end else begin
      r_credit_out <= '0;
      r_rx_done    <= 1'b0;
      if (i_flit_in_wr) begin
        // The router slot is freed even for a dropped flit.
        r_credit_out <= w_vc_valid ? w_in_vc : w_vc_low;
        if (!w_vc_valid) begin
          r_bad_vc <= 1'b1;
        end else if (w_in_tail) begin
          r_rx_done           <= 1'b1;
          r_rx_src_o          <= w_n_src;
          r_rx_len_o          <= w_n_cnt;
          r_rx_err_o          <= w_n_err || r_bad_vc;
          r_bad_vc            <= 1'b0;
          r_rx_act[w_rx_idx]  <= 1'b0;
        end else begin
          r_rx_act[w_rx_idx]  <= 1'b1;
          r_rx_src[w_rx_idx]  <= w_n_src;
          r_rx_cnt[w_rx_idx]  <= w_n_cnt;
          r_rx_err[w_rx_idx]  <= w_n_err;
        end
      end
    end
  end

  assign o_pck_ack     = r_pck_ack;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_flit_out    = r_flit;
  assign o_flit_out_wr = r_flit_wr;
  assign o_credit_out  = r_credit_out;
  assign o_rx_done     = r_rx_done;
  assign o_rx_src      = r_rx_src_o;
  assign o_rx_len      = r_rx_len_o;
  assign o_rx_err      = r_rx_err_o;

endmodule
